// File: rtl/toccata_input_gain.sv
// Stereo capture gain stage: 0..+22.5 dB boost in 1.5 dB steps with one-step-at-a-time ramping,
// 2-cycle pipeline, saturation and sticky clip flags. Define TOCCATA_GAIN_ZC_EN for zero-crossing stepping.
module toccata_input_gain #(
  parameter int RAMP_DIV   = 1,
  parameter int ZC_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic signed [15:0] audio_in_left,
  input  logic signed [15:0] audio_in_right,
  input  logic        [3:0]  gain_left,
  input  logic        [3:0]  gain_right,
  input  logic               clip_clear,
  output logic signed [15:0] audio_out_left,
  output logic signed [15:0] audio_out_right,
  output logic               out_valid,
  output logic               clip_left,
  output logic               clip_right
);

  if (RAMP_DIV < 1 || RAMP_DIV > 255 || ZC_TIMEOUT < 1) begin : g_bad_param
    $error("toccata_input_gain: RAMP_DIV must be 1..255 and ZC_TIMEOUT >= 1");
  end

  // round(4096 * 10^(1.5k/20)) in UQ4.12
  function automatic logic [15:0] gain_factor(input logic [3:0] k);
    logic [15:0] f;
    case (k)
      4'd0:  f = 16'd4096;
      4'd1:  f = 16'd4868;
      4'd2:  f = 16'd5786;
      4'd3:  f = 16'd6876;
      4'd4:  f = 16'd8173;
      4'd5:  f = 16'd9713;
      4'd6:  f = 16'd11544;
      4'd7:  f = 16'd13720;
      4'd8:  f = 16'd16306;
      4'd9:  f = 16'd19380;
      4'd10: f = 16'd23034;
      4'd11: f = 16'd27375;
      4'd12: f = 16'd32536;
      4'd13: f = 16'd38669;
      4'd14: f = 16'd45958;
      default: f = 16'd54621;
    endcase
    return f;
  endfunction

  logic signed [15:0] audio_in [2];
  logic        [3:0]  target   [2];
  logic               valid_s1;

  assign audio_in[0] = audio_in_left;
  assign audio_in[1] = audio_in_right;
  assign target[0]   = gain_left;
  assign target[1]   = gain_right;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      valid_s1  <= sample_valid;
      out_valid <= valid_s1;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic        [3:0]  cur_gain;
    logic        [7:0]  ramp_cnt;
    logic        [7:0]  cnt_inc;
    logic               at_div;
    logic               do_step;
    logic signed [16:0] factor_s;
    logic signed [32:0] prod;
    logic signed [32:0] rounded;
    logic               sat_hi;
    logic               sat_lo;
    logic signed [15:0] sat_val;
    logic signed [15:0] out_q;
    logic               clip_q;

    // Counter saturates at RAMP_DIV so a step held back by zero-crossing stays pending
    assign cnt_inc = (ramp_cnt == 8'(RAMP_DIV)) ? ramp_cnt : ramp_cnt + 8'd1;
    assign at_div  = (cnt_inc == 8'(RAMP_DIV));

`ifdef TOCCATA_GAIN_ZC_EN
    logic        prev_neg;
    logic [15:0] to_cnt;
    logic [15:0] to_inc;
    logic        zero_cross;

    assign to_inc     = to_cnt + 16'd1;
    assign zero_cross = (audio_in[ch] == 16'sd0) || (audio_in[ch][15] != prev_neg);
    assign do_step    = (at_div && zero_cross) || (to_inc >= 16'(ZC_TIMEOUT));

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_neg <= 1'b0;
        to_cnt   <= 16'd0;
      end else begin
        if (sample_valid)
          prev_neg <= audio_in[ch][15];
        if (cur_gain == target[ch])
          to_cnt <= 16'd0;
        else if (sample_valid)
          to_cnt <= do_step ? 16'd0 : to_inc;
      end
    end
`else
    assign do_step = at_div;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        cur_gain <= 4'd0;
        ramp_cnt <= 8'd0;
      end else if (cur_gain == target[ch]) begin
        ramp_cnt <= 8'd0;
      end else if (sample_valid) begin
        if (do_step) begin
          cur_gain <= (cur_gain < target[ch]) ? cur_gain + 4'd1 : cur_gain - 4'd1;
          ramp_cnt <= 8'd0;
        end else begin
          ramp_cnt <= cnt_inc;
        end
      end
    end

    assign factor_s = {1'b0, gain_factor(cur_gain)};
    assign rounded  = (prod + 33'sd2048) >>> 12;
    assign sat_hi   = rounded > 33'sd32767;
    assign sat_lo   = rounded < -33'sd32768;

    always_comb begin
      sat_val = rounded[15:0];
      if (sat_hi)
        sat_val = 16'sh7FFF;
      else if (sat_lo)
        sat_val = 16'sh8000;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        prod   <= 33'sd0;
        out_q  <= 16'sd0;
        clip_q <= 1'b0;
      end else begin
        if (sample_valid)
          prod <= 33'(audio_in[ch]) * 33'(factor_s);
        if (valid_s1)
          out_q <= sat_val;
        // A saturation landing in the same cycle as a clear keeps the flag set
        if (valid_s1 && (sat_hi || sat_lo))
          clip_q <= 1'b1;
        else if (clip_clear)
          clip_q <= 1'b0;
      end
    end
  end

  assign audio_out_left  = g_ch[0].out_q;
  assign audio_out_right = g_ch[1].out_q;
  assign clip_left       = g_ch[0].clip_q;
  assign clip_right      = g_ch[1].clip_q;

endmodule

// File: tb/tb_toccata_input_gain.sv
// Randomized self-checking bench for toccata_input_gain against a per-sample reference model.
module tb_toccata_input_gain;

  localparam int RAMP_DIV   = 1;
  localparam int ZC_TIMEOUT = 64;
`ifdef TOCCATA_GAIN_ZC_EN
  localparam bit ZC_EN = 1'b1;
`else
  localparam bit ZC_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] audio_in_left, audio_in_right;
  logic        [3:0]  gain_left, gain_right;
  logic               clip_clear;
  logic signed [15:0] audio_out_left, audio_out_right;
  logic               out_valid, clip_left, clip_right;

  always #5 clk = ~clk;

  toccata_input_gain #(.RAMP_DIV(RAMP_DIV), .ZC_TIMEOUT(ZC_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .audio_in_left(audio_in_left), .audio_in_right(audio_in_right),
    .gain_left(gain_left), .gain_right(gain_right), .clip_clear(clip_clear),
    .audio_out_left(audio_out_left), .audio_out_right(audio_out_right),
    .out_valid(out_valid), .clip_left(clip_left), .clip_right(clip_right)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: gain state per channel, one sample in flight, then the visible outputs
  int     fac [16];
  int     m_cur [2], m_cnt [2], m_to [2];
  bit     m_prevneg [2];
  bit     p_valid;
  longint p_out [2];
  bit     p_sat [2];
  bit     v_valid;
  longint v_out [2];
  bit     v_clip [2];

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid",  longint'(out_valid),       longint'(v_valid));
    checkOutput("out_left",   longint'(audio_out_left),  v_out[0]);
    checkOutput("out_right",  longint'(audio_out_right), v_out[1]);
    checkOutput("clip_left",  longint'(clip_left),       longint'(v_clip[0]));
    checkOutput("clip_right", longint'(clip_right),      longint'(v_clip[1]));
  endtask

  task automatic modelClear();
    for (int ch = 0; ch < 2; ch++) begin
      m_cur[ch] = 0; m_cnt[ch] = 0; m_to[ch] = 0; m_prevneg[ch] = 0;
      p_out[ch] = 0; p_sat[ch] = 0; v_out[ch] = 0; v_clip[ch] = 0;
    end
    p_valid = 0;
    v_valid = 0;
  endtask

  task automatic applyReset(input bit v);
    rst = 1'b1;
    sample_valid = v;
    audio_in_left = 16'($urandom);
    audio_in_right = 16'($urandom);
    clip_clear = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    modelClear();
    checkAll();
  endtask

  task automatic applyStimulus(input bit v, input int l, input int r,
                               input int tl, input int tr, input bit clr);
    int     x [2];
    int     t [2];
    longint prod, res;
    bit     zc, step;
    x[0] = l; x[1] = r; t[0] = tl; t[1] = tr;
    sample_valid = v;
    audio_in_left = 16'(l);
    audio_in_right = 16'(r);
    gain_left = 4'(tl);
    gain_right = 4'(tr);
    clip_clear = clr;

    // Visible outputs after this edge come from the sample already in flight
    v_valid = p_valid;
    for (int ch = 0; ch < 2; ch++) begin
      if (p_valid) v_out[ch] = p_out[ch];
      if (p_valid && p_sat[ch]) v_clip[ch] = 1;
      else if (clr) v_clip[ch] = 0;
    end

    p_valid = v;
    for (int ch = 0; ch < 2; ch++) begin
      if (v) begin
        prod = longint'(x[ch]) * longint'(fac[m_cur[ch]]);
        res = (prod + 2048) >>> 12;
        p_sat[ch] = (res > 32767) || (res < -32768);
        p_out[ch] = (res > 32767) ? 32767 : (res < -32768) ? -32768 : res;
      end
      if (m_cur[ch] == t[ch]) begin
        m_cnt[ch] = 0;
        m_to[ch] = 0;
      end else if (v) begin
        if (m_cnt[ch] < RAMP_DIV) m_cnt[ch]++;
        m_to[ch]++;
        zc = (x[ch] == 0) || ((x[ch] < 0) != m_prevneg[ch]);
        step = (m_cnt[ch] == RAMP_DIV) && (zc || !ZC_EN);
        if (ZC_EN && m_to[ch] >= ZC_TIMEOUT) step = 1;
        if (step) begin
          m_cur[ch] += (t[ch] > m_cur[ch]) ? 1 : -1;
          m_cnt[ch] = 0;
          m_to[ch] = 0;
        end
      end
      if (v) m_prevneg[ch] = (x[ch] < 0);
    end

    @(posedge clk); #1;
    checkAll();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int tl, tr;
    for (int k = 0; k < 16; k++)
      fac[k] = int'($floor(4096.0 * $pow(10.0, 1.5 * k / 20.0) + 0.5));
    rst = 1'b1; sample_valid = 1'b0; clip_clear = 1'b0;
    audio_in_left = '0; audio_in_right = '0; gain_left = '0; gain_right = '0;
    modelClear();
    @(negedge clk);
    applyReset(1'b0);

    // Unity gain passes samples through with two cycles of latency
    applyStimulus(1, 12345, -12345, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("unity_left", longint'(audio_out_left), 12345);
    checkOutput("unity_right", longint'(audio_out_right), -12345);

    // Ramp up to +22.5 dB, then the spec example values
    for (int i = 0; i < 16; i++) applyStimulus(1, rnd_sample() / 16, rnd_sample() / 16, 15, 15, 0);
    applyStimulus(1, 1000, -1000, 15, 15, 0);
    applyStimulus(0, 0, 0, 15, 15, 0);
    applyStimulus(0, 0, 0, 15, 15, 0);
    checkOutput("max_gain_left", longint'(audio_out_left), 13335);
    checkOutput("max_gain_right", longint'(audio_out_right), -13335);

    // Settle at code 4 and saturate both channels
    for (int i = 0; i < 12; i++) applyStimulus(1, rnd_sample() / 8, rnd_sample() / 8, 4, 4, 0);
    applyStimulus(1, 30000, -30000, 4, 4, 0);
    applyStimulus(0, 0, 0, 4, 4, 0);
    applyStimulus(0, 0, 0, 4, 4, 0);
    checkOutput("sat_left", longint'(audio_out_left), 32767);
    checkOutput("sat_right", longint'(audio_out_right), -32768);
    checkOutput("clip_set_left", longint'(clip_left), 1);
    applyStimulus(0, 0, 0, 4, 4, 1);
    checkOutput("clip_cleared_right", longint'(clip_right), 0);

    // Clear arriving together with a new saturation: set wins
    applyStimulus(1, 30000, -30000, 4, 4, 0);
    applyStimulus(0, 0, 0, 4, 4, 1);
    checkOutput("clip_set_wins_left", longint'(clip_left), 1);
    checkOutput("clip_set_wins_right", longint'(clip_right), 1);
    applyStimulus(0, 0, 0, 4, 4, 1);

    // Ramp up then symmetrically down
    for (int i = 0; i < 16; i++) applyStimulus(1, rnd_sample() / 16, rnd_sample() / 16, 15, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, rnd_sample() / 16, rnd_sample() / 16, 0, 15, 0);

    // Reset mid-ramp with two samples in flight; gain restarts from code 0
    for (int i = 0; i < 5; i++) applyStimulus(1, rnd_sample(), rnd_sample(), 15, 15, 0);
    applyStimulus(1, 500, -500, 15, 15, 0);
    applyStimulus(1, 600, -600, 15, 15, 0);
    applyReset(1'b1);
    applyStimulus(1, 1000, -1000, 15, 15, 0);
    applyStimulus(0, 0, 0, 15, 15, 0);
    applyStimulus(0, 0, 0, 15, 15, 0);
    checkOutput("restart_left", longint'(audio_out_left), 1000);

    // DC input toward a new target: exercises the timeout path when zero-crossing is built
    applyReset(1'b0);
    for (int i = 0; i < 70; i++) applyStimulus(1, 1000, -1000, 1, 1, 0);

    // Random traffic with target changes, clears and occasional resets
    tl = 0; tr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) tl = int'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) tr = int'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0)
        applyReset(1'($urandom));
      else
        applyStimulus($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample(), tl, tr,
                      $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
